// File: rtl/mux_2x1_rr_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 data mux into a one-entry output register.
// Optional burst locking is enabled with `define ARB_BURST_LOCK_EN.
module mux_2x1_rr_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COMMMAND_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
  input  logic [1:0]                i_last,
  output logic [1:0]                o_ready,
  input  logic                      i_en,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data_bus,
  output logic [COMMMAND_WIDTH-1:0] o_cmd,
  input  logic                      i_ready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_cmd;
  logic                  r_ptr;

  logic                  w_space;
  logic                  w_accept;
  logic                  w_gnt;
  logic                  w_gnt_vld;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_lane;

`ifdef ARB_BURST_LOCK_EN
  typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;
  lock_state_e r_state;
  logic        r_lock_id;
`else
  logic w_unused_last;
  assign w_unused_last = ^i_last;
`endif

  assign w_space  = !r_valid || i_ready;
  assign w_accept = i_en && w_space && !rst;

  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_vld = 1'b0;
`ifdef ARB_BURST_LOCK_EN
    if (r_state == StLocked) begin
      // Only the burst owner may be granted until its last beat.
      w_gnt     = r_lock_id;
      w_gnt_vld = i_valid[r_lock_id];
    end else
`endif
    begin
      unique case (i_valid)
        2'b01:   begin w_gnt = 1'b0;  w_gnt_vld = 1'b1; end
        2'b10:   begin w_gnt = 1'b1;  w_gnt_vld = 1'b1; end
        2'b11:   begin w_gnt = r_ptr; w_gnt_vld = 1'b1; end
        default: begin w_gnt = 1'b0;  w_gnt_vld = 1'b0; end
      endcase
    end
  end

  assign w_xfer = w_accept && w_gnt_vld;
  assign w_lane = w_gnt ? i_data_bus[DATA_WIDTH +: DATA_WIDTH] : i_data_bus[DATA_WIDTH-1:0];

  always_comb begin
    o_ready = 2'b00;
    if (w_xfer) o_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cmd   <= 1'b0;
      r_ptr   <= 1'b0;
`ifdef ARB_BURST_LOCK_EN
      r_state   <= StUnlocked;
      r_lock_id <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_lane;
      r_cmd   <= w_gnt;
`ifdef ARB_BURST_LOCK_EN
      if (r_state == StUnlocked) begin
        r_ptr <= ~w_gnt;
        if (!i_last[w_gnt]) begin
          r_state   <= StLocked;
          r_lock_id <= w_gnt;
        end
      end else if (i_last[r_lock_id]) begin
        r_state <= StUnlocked;
        r_ptr   <= ~r_lock_id;
      end
`else
      r_ptr <= ~w_gnt;
`endif
    end else if (r_valid && i_ready) begin
      // Drained with nothing new: park a zero beat, keep the last command.
      r_valid <= 1'b0;
      r_data  <= '0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data_bus = r_data;
  assign o_cmd      = COMMMAND_WIDTH'(r_cmd);

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_mux_2x1_rr_arbiter;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic [1:0]    i_last;
  logic [1:0]    o_ready;
  logic          i_en;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic [0:0]    o_cmd;
  logic          i_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who is favoured, which requester owns a burst (-1 = none), output slot.
  int          m_ptr;
  int          m_lock;
  bit          m_valid;
  logic [DW-1:0] m_data;
  int          m_cmd;

  always #5 clk = ~clk;

  mux_2x1_rr_arbiter #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .i_en       (i_en),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .i_ready    (i_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check the combinational ready, advance the model, check registered outputs.
  task automatic cycle();
    int   g;
    bit   acc;
    logic [1:0] er;
    #1;
    g = -1;
    if (m_lock >= 0) begin
      if (i_valid[m_lock]) g = m_lock;
    end else if (i_valid == 2'b11) g = m_ptr;
    else if (i_valid == 2'b01) g = 0;
    else if (i_valid == 2'b10) g = 1;
    acc = i_en && (!m_valid || i_ready) && !rst;
    er = 2'b00;
    if (acc && g >= 0) er[g] = 1'b1;
    check_eq("o_ready", {62'd0, o_ready}, {62'd0, er});
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_lock = -1; m_valid = 0; m_data = '0; m_cmd = 0;
    end else if (er != 2'b00) begin
      m_valid = 1;
      m_data  = (g == 1) ? i_data_bus[2*DW-1:DW] : i_data_bus[DW-1:0];
      m_cmd   = g;
`ifdef ARB_BURST_LOCK_EN
      if (m_lock < 0 && !i_last[g]) m_lock = g;
      else if (m_lock >= 0 && i_last[g]) m_lock = -1;
      if (m_lock < 0) m_ptr = 1 - g;
`else
      m_ptr = 1 - g;
`endif
    end else if (m_valid && i_ready) begin
      m_valid = 0;
      m_data  = '0;
    end
    #1;
    check_eq("o_valid", {63'd0, o_valid}, {63'd0, m_valid});
    check_eq("o_data_bus", {32'd0, o_data_bus}, {32'd0, m_data});
    check_eq("o_cmd", {63'd0, o_cmd}, 64'(m_cmd));
  endtask

  initial begin
    logic [DW-1:0] held_d;
    logic [0:0]    held_c;
    m_ptr = 0; m_lock = -1; m_valid = 0; m_data = '0; m_cmd = 0;

    // Reset with both requesters valid.
    rst = 1; i_valid = 2'b11; i_en = 1; i_ready = 1; i_last = 2'b00;
    i_data_bus = {32'hFFFF_FFFF, 32'hAAAA_AAAA};
    @(posedge clk); #1;
    repeat (2) cycle();
    check_eq("reset_valid", {63'd0, o_valid}, 64'd0);
    check_eq("reset_ready", {62'd0, o_ready}, 64'd0);
    rst = 0;
    i_last = 2'b11;

    // Alternation.
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("alt_data", {32'd0, o_data_bus}, (i % 2) ? 64'hFFFF_FFFF : 64'hAAAA_AAAA);
      check_eq("alt_cmd", {63'd0, o_cmd}, 64'(i % 2));
    end

    // Single requester, then both: low first.
    i_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("single_cmd", {63'd0, o_cmd}, 64'd1);
    end
    i_valid = 2'b11;
    cycle();
    check_eq("after_single_low", {63'd0, o_cmd}, 64'd0);

    // Backpressure.
    i_ready = 0;
    held_d = o_data_bus; held_c = o_cmd;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_data", {32'd0, o_data_bus}, {32'd0, held_d});
      check_eq("bp_cmd", {63'd0, o_cmd}, {63'd0, held_c});
    end
    i_ready = 1;
    cycle();
    check_eq("bp_resume_cmd", {63'd0, o_cmd}, 64'd1);

    // Enable gating: drain then idle zero beat, pointer kept.
    i_en = 0;
    repeat (2) cycle();
    check_eq("en_drain_valid", {63'd0, o_valid}, 64'd0);
    check_eq("en_drain_data", {32'd0, o_data_bus}, 64'd0);
    i_en = 1;
    cycle();
    check_eq("en_resume_cmd", {63'd0, o_cmd}, 64'd0);

`ifdef ARB_BURST_LOCK_EN
    // Burst lock: make low favoured, then low sends a 3-beat burst.
    i_valid = 2'b10; i_last = 2'b11;
    cycle();
    i_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      i_last = (i == 2) ? 2'b01 : 2'b00;
      cycle();
      check_eq("burst_low", {63'd0, o_cmd}, 64'd0);
    end
    i_last = 2'b11;
    cycle();
    check_eq("burst_then_high", {63'd0, o_cmd}, 64'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      i_valid    = 2'($urandom);
      i_data_bus = {$urandom, $urandom};
      i_last     = 2'($urandom);
      i_en       = ($urandom_range(0, 7) != 0);
      i_ready    = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
- Round-robin controller that shares the 2:1 datapath mux between two requesters, low (index 0) and high (index 1).
- Arbitrates between the two valid/ready input streams and generates the mux select.
- Registers the selected beat into a single-entry output stage with valid/ready backpressure.
- Sits in front of a downstream router or buffer stage in the NoC datapath.

Parameters:
DATA_WIDTH, 32, width of one data lane; i_data_bus carries two lanes.
COMMMAND_WIDTH, 1, width of o_cmd; 1 selects high, 0 selects low.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
i_valid  input  2  per-requester valid; bit 0 is low, bit 1 is high.
i_data_bus  input  2*DATA_WIDTH  high lane [DATA_WIDTH+:DATA_WIDTH], low lane [DATA_WIDTH-1:0].
i_last  input  2  per-requester end-of-burst flag; used only with ARB_BURST_LOCK_EN.
o_ready  output  2  per-requester ready (combinational); transfer occurs when i_valid[k] && o_ready[k].
i_en  input  1  arbiter enable; 0 blocks new grants.
o_valid  output  1  output register holds a valid beat.
o_data_bus  output  DATA_WIDTH  registered selected data.
o_cmd  output  COMMMAND_WIDTH  registered grant index of the current output beat.
i_ready  input  1  downstream ready.

Behaviour:
- Reset values (rst=1 at clock edge): o_valid=0, o_data_bus=0, o_cmd=0, priority pointer ptr=0 (low favoured first), lock state UNLOCKED.
- o_ready=0 for any cycle in which rst=1.
- space = !o_valid || i_ready. accept = i_en && space && !rst.
- Grant g, combinational:
  - only one valid: g is that requester.
  - both valid: g=ptr.
  - none valid: no grant.
- o_ready[g]=accept for the granted requester; the other requester's o_ready is 0. Both o_ready bits are 0 when accept=0.
- On a transfer, at the next edge:
  - o_data_bus <= lane g; o_cmd <= g; o_valid <= 1.
  - ptr <= ~g.
- Latency: 1 cycle from input handshake to o_valid. Throughput: 1 beat/cycle while i_ready=1.
- Output drains (o_valid && i_ready) with no new transfer: o_valid<=0 and o_data_bus<=0 (dummy zero); o_cmd holds its value.
- Backpressure: while o_valid=1 and i_ready=0:
  - o_data_bus and o_cmd are stable.
  - both o_ready bits are 0.
  - ptr is frozen.
- i_en=0: no transfers and ptr frozen. The output register still drains on i_ready.
- Simultaneous drain and transfer: the new beat replaces the old one; o_valid stays 1 with no bubble.
- Requester dropping i_valid without a handshake is legal: ptr does not advance and no state changes.
- Reset mid-operation: any held beat is discarded; state returns to the reset values on that edge.

Optional Feature:
Macro: ARB_BURST_LOCK_EN.
- Defined: adds a 2-state FSM with states UNLOCKED and LOCKED(id).
  - UNLOCKED→LOCKED(g): on a transfer with i_last[g]=0.
  - In LOCKED(id): only requester id can be granted. The other requester's o_ready=0 even if it is the sole valid requester. ptr does not update.
  - LOCKED→UNLOCKED: on the transfer with i_last[id]=1; ptr <= ~id on that beat.
  - A transfer with i_last=1 while UNLOCKED is a single-beat burst and arbitrates normally.
  - rst forces UNLOCKED.
- Undefined: i_last is ignored and every beat arbitrates independently; the FSM is absent.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles with i_valid=2'b11 -> o_valid=0, o_data_bus=0, o_cmd=0, o_ready=2'b00.
- Alternation: i_valid=2'b11, high lane=32'hFFFFFFFF, low lane=32'hAAAAAAAA, i_en=1, i_ready=1 for 4 cycles -> o_data_bus sequence AAAAAAAA, FFFFFFFF, AAAAAAAA, FFFFFFFF; o_cmd sequence 0,1,0,1; o_ready alternates 01,10.
- Single requester: i_valid=2'b10 for 3 cycles -> high granted every cycle, o_cmd=1; a subsequent 2'b11 grants low first.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 -> o_data_bus/o_cmd constant, o_ready=00; raising i_ready resumes with the next grant and no lost or duplicated beat.
- Enable gating: i_en=0 with i_valid=2'b11 and i_ready=1 -> the held beat drains, then o_valid=0 and o_data_bus=0; ptr is unchanged when i_en returns to 1.
- Burst lock (macro defined): low sends 3 beats with i_last=0,0,1 while high is valid throughout -> 3 consecutive o_cmd=0 beats, then high is granted on the next cycle.
